// File: rtl/smol_wb_pkg.sv
// Shared types and constants for the smol_writeback stage.
package smol_wb_pkg;

   localparam int XLEN = 32;

   // RISC-V load size/sign encodings carried in funct3.
   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_e;

   // Writeback FSM states.
   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } wb_state_e;

endpackage

// File: rtl/smol_load_align.sv
// Load data formatter: selects the addressed byte/half from an aligned
// memory word and sign- or zero-extends it according to funct3.
module smol_load_align
   import smol_wb_pkg::*;
(
   input  logic [XLEN-1:0] word,
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   output logic [XLEN-1:0] data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Pick the byte lane addressed by the low address bits.
   always_comb begin
      sel_byte = word[7:0];
      case (offset)
         2'd0:    sel_byte = word[7:0];
         2'd1:    sel_byte = word[15:8];
         2'd2:    sel_byte = word[23:16];
         default: sel_byte = word[31:24];
      endcase
   end

   // Halfword lane depends only on offset[1]; offset[0] is ignored.
   always_comb begin
      sel_half = offset[1] ? word[31:16] : word[15:0];
   end

   // Extend the selected lane; unknown encodings pass the word through.
   always_comb begin
      data = word;
      case (funct3)
         LB:      data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
         LH:      data = {{(XLEN-16){sel_half[15]}}, sel_half};
         LW:      data = word;
         LBU:     data = {{(XLEN-8){1'b0}}, sel_byte};
         LHU:     data = {{(XLEN-16){1'b0}}, sel_half};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/smol_writeback.sv
// smol_writeback: last pipeline stage, drives the smolRF write port.
// ALU results are written the cycle after acceptance; loads park in
// WAIT_LOAD until the data-memory response, then are aligned and written.
// Build option SMOL_WB_BYPASS_EN adds fwdValid/fwdAddr/fwdData outputs that
// combinationally mirror the write port for same-cycle decode bypass.
module smol_writeback
   import smol_wb_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inValid,
   output logic             inReady,
   input  logic             inRegWrite,
   input  logic             inIsLoad,
   input  logic [4:0]       inRd,
   input  logic [2:0]       inFunct3,
   input  logic [XLEN-1:0]  inAluResult,
   input  logic             memRspValid,
   input  logic [XLEN-1:0]  memRspData,
   input  logic             flush,
   output logic             wEnable,
   output logic [4:0]       wAddr,
   output logic [XLEN-1:0]  wData,
   output logic [CNT_W-1:0] retireCount,
`ifdef SMOL_WB_BYPASS_EN
   output logic             fwdValid,
   output logic [4:0]       fwdAddr,
   output logic [XLEN-1:0]  fwdData,
`endif
   output logic             rspErr
);

   wb_state_e       state;
   wb_state_e       state_next;
   logic            take;
   logic            retire_alu;
   logic            retire_load;
   logic [4:0]      cap_rd;
   logic            cap_reg_write;
   logic [2:0]      cap_funct3;
   logic [1:0]      cap_offset;
   logic [XLEN-1:0] load_data;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next state: a load parks the stage until its response or a flush.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (take && inIsLoad)        state_next = WAIT_LOAD;
         WAIT_LOAD: if (flush || memRspValid)    state_next = IDLE;
         default:                                state_next = IDLE;
      endcase
   end

   // FSM outputs: handshake and the two retirement events.
   always_comb begin
      inReady     = (state == IDLE) && !flush;
      take        = inValid && inReady;
      retire_alu  = take && !inIsLoad;
      retire_load = (state == WAIT_LOAD) && memRspValid && !flush;
   end

   // Hold the load's destination and formatting info while waiting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_rd        <= 5'd0;
         cap_reg_write <= 1'b0;
         cap_funct3    <= 3'd0;
         cap_offset    <= 2'd0;
      end else if (take && inIsLoad) begin
         cap_rd        <= inRd;
         cap_reg_write <= inRegWrite;
         cap_funct3    <= inFunct3;
         cap_offset    <= inAluResult[1:0];
      end
   end

   smol_load_align u_align (
      .word   (memRspData),
      .funct3 (cap_funct3),
      .offset (cap_offset),
      .data   (load_data)
   );

   // Registered RF write port; enable pulses for one cycle, addr/data hold.
   // Writes to x0 still retire but never raise the enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wEnable <= 1'b0;
         wAddr   <= 5'd0;
         wData   <= '0;
      end else begin
         wEnable <= 1'b0;
         if (retire_alu) begin
            wEnable <= inRegWrite && (inRd != 5'd0);
            wAddr   <= inRd;
            wData   <= inAluResult;
         end else if (retire_load) begin
            wEnable <= cap_reg_write && (cap_rd != 5'd0);
            wAddr   <= cap_rd;
            wData   <= load_data;
         end
      end
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           retireCount <= '0;
      else if (retire_alu || retire_load) retireCount <= retireCount + CNT_W'(1);
   end

   // Sticky flag for a memory response with no load outstanding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               rspErr <= 1'b0;
      else if (state == IDLE && memRspValid)  rspErr <= 1'b1;
   end

`ifdef SMOL_WB_BYPASS_EN
   assign fwdValid = wEnable & rst;
   assign fwdAddr  = wAddr;
   assign fwdData  = wData;
`endif

endmodule

// File: tb/tb_smol_writeback.sv
// Scoreboard bench for smol_writeback: a transaction-level model predicts
// RF writes, retire count and rspErr; a negedge monitor checks the DUT.
module tb_smol_writeback;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_reg_write = 1'b0;
   logic        in_is_load = 1'b0;
   logic [4:0]  in_rd = 5'd0;
   logic [2:0]  in_funct3 = 3'd0;
   logic [31:0] in_alu = 32'd0;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = 32'd0;
   logic        flush = 1'b0;
   logic        w_enable;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic [31:0] retire_count;
   logic        rsp_err;
`ifdef SMOL_WB_BYPASS_EN
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   smol_writeback #(.XLEN(32), .CNT_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .inValid     (in_valid),
      .inReady     (in_ready),
      .inRegWrite  (in_reg_write),
      .inIsLoad    (in_is_load),
      .inRd        (in_rd),
      .inFunct3    (in_funct3),
      .inAluResult (in_alu),
      .memRspValid (mem_rsp_valid),
      .memRspData  (mem_rsp_data),
      .flush       (flush),
      .wEnable     (w_enable),
      .wAddr       (w_addr),
      .wData       (w_data),
      .retireCount (retire_count),
`ifdef SMOL_WB_BYPASS_EN
      .fwdValid    (fwd_valid),
      .fwdAddr     (fwd_addr),
      .fwdData     (fwd_data),
`endif
      .rspErr      (rsp_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference load formatting written from the ISA definition.
   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> (8 * off));
      h = 16'(word >> (16 * off[1]));
      case (f3)
         3'b000:  return 32'($signed(b));
         3'b001:  return 32'($signed(h));
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic        m_wait = 1'b0;
   logic [31:0] m_cnt = 32'd0;
   logic        m_err = 1'b0;
   logic [4:0]  m_rd = 5'd0;
   logic        m_rw = 1'b0;
   logic [2:0]  m_f3 = 3'd0;
   logic [1:0]  m_off = 2'd0;

   // Behavioural model: one step per clock, expected writes go to the queue.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_wait <= 1'b0;
         m_cnt  <= 32'd0;
         m_err  <= 1'b0;
         exp_q.delete();
      end else if (!m_wait) begin
         if (mem_rsp_valid) m_err <= 1'b1;
         if (in_valid && !flush) begin
            if (in_is_load) begin
               m_wait <= 1'b1;
               m_rd   <= in_rd;
               m_rw   <= in_reg_write;
               m_f3   <= in_funct3;
               m_off  <= in_alu[1:0];
            end else begin
               m_cnt <= m_cnt + 32'd1;
               if (in_reg_write && in_rd != 5'd0)
                  exp_q.push_back('{addr: in_rd, data: in_alu});
            end
         end
      end else if (flush) begin
         m_wait <= 1'b0;
      end else if (mem_rsp_valid) begin
         m_wait <= 1'b0;
         m_cnt  <= m_cnt + 32'd1;
         if (m_rw && m_rd != 5'd0)
            exp_q.push_back('{addr: m_rd, data: ref_load(mem_rsp_data, m_f3, m_off)});
      end
   end

   // Monitor: compare every cycle on the falling edge.
   always @(negedge clk) begin
      wr_t e;
      logic exp_w;
      exp_w = (exp_q.size() != 0);
      e = '{addr: 5'd0, data: 32'd0};
      if (exp_w) e = exp_q.pop_front();
      chk("wEnable", {31'd0, w_enable}, {31'd0, exp_w});
      if (exp_w && w_enable) begin
         chk("wAddr", {27'd0, w_addr}, {27'd0, e.addr});
         chk("wData", w_data, e.data);
      end
`ifdef SMOL_WB_BYPASS_EN
      chk("fwdValid", {31'd0, fwd_valid}, {31'd0, exp_w});
      if (exp_w) begin
         chk("fwdAddr", {27'd0, fwd_addr}, {27'd0, e.addr});
         chk("fwdData", fwd_data, e.data);
      end
`endif
      chk("retireCount", retire_count, m_cnt);
      chk("rspErr", {31'd0, rsp_err}, {31'd0, m_err});
      chk("inReady", {31'd0, in_ready}, {31'd0, (!m_wait && !flush)});
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      in_valid      = 1'b0;
      in_is_load    = 1'b0;
      mem_rsp_valid = 1'b0;
      flush         = 1'b0;
   endtask

   task automatic set_op(input logic ld, input logic rw, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] alu);
      in_valid     = 1'b1;
      in_is_load   = ld;
      in_reg_write = rw;
      in_rd        = rd;
      in_funct3    = f3;
      in_alu       = alu;
   endtask

   task automatic respond(input logic [31:0] d);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d;
   endtask

   initial begin
      idle_in();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset wEnable", {31'd0, w_enable}, 32'd0);
      chk("reset wAddr", {27'd0, w_addr}, 32'd0);
      chk("reset wData", w_data, 32'd0);
      chk("reset retireCount", retire_count, 32'd0);
      chk("reset rspErr", {31'd0, rsp_err}, 32'd0);
      nxt();
      rst = 1'b1;

      // ALU op to x5
      nxt(); set_op(1'b0, 1'b1, 5'd5, 3'd0, 32'h0000_0010);
      nxt(); idle_in();
      @(negedge clk);
      chk("alu wEnable", {31'd0, w_enable}, 32'd1);
      chk("alu wAddr", {27'd0, w_addr}, 32'd5);
      chk("alu wData", w_data, 32'h10);
      chk("alu retireCount", retire_count, 32'd1);

      // LB at offset 3
      nxt(); set_op(1'b1, 1'b1, 5'd7, 3'b000, 32'h0000_1003);
      nxt(); idle_in();
      @(negedge clk);
      chk("lb stall inReady", {31'd0, in_ready}, 32'd0);
      nxt(); nxt(); respond(32'h80FF_FF7F);
      nxt(); idle_in();
      @(negedge clk);
      chk("lb wAddr", {27'd0, w_addr}, 32'd7);
      chk("lb wData", w_data, 32'hFFFF_FF80);
      chk("lb inReady", {31'd0, in_ready}, 32'd1);

      // LHU at offset 2
      nxt(); set_op(1'b1, 1'b1, 5'd9, 3'b101, 32'h0000_2002);
      nxt(); idle_in(); respond(32'hBEEF_1234);
      nxt(); idle_in();
      @(negedge clk);
      chk("lhu wData", w_data, 32'h0000_BEEF);
      chk("lhu retireCount", retire_count, 32'd3);

      // ALU op to x0 retires without a write
      nxt(); set_op(1'b0, 1'b1, 5'd0, 3'd0, 32'hDEAD_BEEF);
      nxt(); idle_in();
      @(negedge clk);
      chk("x0 wEnable", {31'd0, w_enable}, 32'd0);
      chk("x0 retireCount", retire_count, 32'd4);

      // Flush with simultaneous response drops the load
      nxt(); set_op(1'b1, 1'b1, 5'd3, 3'b010, 32'h0000_0000);
      nxt(); idle_in(); flush = 1'b1; respond(32'h1234_5678);
      nxt(); idle_in();
      @(negedge clk);
      chk("flush wEnable", {31'd0, w_enable}, 32'd0);
      chk("flush retireCount", retire_count, 32'd4);
      chk("flush inReady", {31'd0, in_ready}, 32'd1);
      chk("flush rspErr", {31'd0, rsp_err}, 32'd0);

      // Stray response while idle
      nxt(); respond(32'hCAFE_F00D);
      nxt(); idle_in();
      @(negedge clk);
      chk("stray rspErr", {31'd0, rsp_err}, 32'd1);
      repeat (3) nxt();
      @(negedge clk);
      chk("sticky rspErr", {31'd0, rsp_err}, 32'd1);

      // Back-to-back ALU ops
      nxt();
      for (int i = 0; i < 4; i++) begin
         set_op(1'b0, 1'b1, 5'(10 + i), 3'd0, 32'(i * 32'h111 + 1));
         nxt();
      end
      idle_in();
      @(negedge clk);
      chk("b2b retireCount", retire_count, 32'd8);
      chk("b2b last wAddr", {27'd0, w_addr}, 32'd13);

      // Reset while a load is pending, then a late response
      nxt(); set_op(1'b1, 1'b1, 5'd4, 3'b000, 32'h0000_0001);
      nxt(); idle_in(); rst = 1'b0;
      @(negedge clk);
      chk("rst-wait retireCount", retire_count, 32'd0);
      chk("rst-wait rspErr", {31'd0, rsp_err}, 32'd0);
      nxt(); rst = 1'b1;
      nxt(); respond(32'h0000_00AA);
      nxt(); idle_in();
      @(negedge clk);
      chk("late rsp wEnable", {31'd0, w_enable}, 32'd0);
      chk("late rsp rspErr", {31'd0, rsp_err}, 32'd1);

      // Randomized traffic
      nxt();
      rst = 1'b0;
      nxt();
      rst = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         in_valid      = ($urandom_range(0, 3) != 0);
         in_reg_write  = ($urandom_range(0, 3) != 0);
         in_is_load    = ($urandom_range(0, 2) == 0);
         in_rd         = 5'($urandom);
         in_funct3     = 3'($urandom);
         in_alu        = $urandom;
         mem_rsp_valid = ($urandom_range(0, 3) == 0);
         mem_rsp_data  = $urandom;
         flush         = ($urandom_range(0, 11) == 0);
         nxt();
      end
      idle_in();
      repeat (3) nxt();
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/smol_writeback.md
Name: smol_writeback

Overview:
- Final pipeline stage directly upstream of smolRF; drives its write port (wEnable/wAddr/wData).
- Accepts one retiring instruction per handshake from the memory stage.
- ALU results write back on the next cycle. Loads stall the stage until the data-memory response returns, then are byte/half aligned and sign/zero extended before the write.
- Maintains a retired-instruction counter for performance debug.

Parameters:
- XLEN, 32, datapath width; must be 32.
- CNT_W, 32, width of retireCount.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- inValid  in  1  memory stage presents an instruction.
- inReady  out  1  stage accepts; combinational, equals (state==IDLE && !flush).
- inRegWrite  in  1  instruction writes rd.
- inIsLoad  in  1  instruction is a load.
- inRd  in  5  destination register.
- inFunct3  in  3  load size/sign encoding.
- inAluResult  in  XLEN  ALU result, or load effective address.
- memRspValid  in  1  data-memory response strobe.
- memRspData  in  XLEN  aligned 32-bit word read from memory.
- flush  in  1  abandon in-flight load; blocks acceptance this cycle.
- wEnable  out  1  to smolRF write enable.
- wAddr  out  5  to smolRF write address.
- wData  out  XLEN  to smolRF write data.
- retireCount  out  CNT_W  completed instructions.
- rspErr  out  1  sticky: response arrived with no load pending.

Behaviour:
- Reset (rst low, async): state=IDLE; wEnable=0, wAddr=0, wData=0, retireCount=0, rspErr=0, captured load fields=0.
- wEnable/wAddr/wData are registered. Default each cycle: wEnable=0; wAddr/wData hold their last value.
- A transfer occurs when inValid && inReady.
- IDLE, transfer with !inIsLoad:
  - Next cycle: wEnable = inRegWrite && (inRd!=0), wAddr=inRd, wData=inAluResult.
  - retireCount+1.
  - Stay IDLE.
- IDLE, transfer with inIsLoad:
  - Capture inRd, inRegWrite, inFunct3 and offset=inAluResult[1:0].
  - Go to WAIT_LOAD; inReady drops next cycle.
- WAIT_LOAD, memRspValid && !flush:
  - Next cycle: wEnable = capRegWrite && capRd!=0, wAddr=capRd, wData=align(memRspData).
  - retireCount+1; go to IDLE. The next instruction can be accepted the cycle after the response.
- WAIT_LOAD, flush (regardless of memRspValid): no write, no count, go to IDLE.
- memRspValid while IDLE: ignored for data; rspErr<=1 (sticky until reset).
- IDLE, flush high: inReady=0, so no transfer occurs; state unchanged.
- Load alignment by funct3:
  - 000 LB: sign-extend byte[offset].
  - 001 LH: sign-extend half[offset[1]] (offset[0] ignored).
  - 010 LW: word unchanged.
  - 100 LBU: zero-extend byte[offset].
  - 101 LHU: zero-extend half[offset[1]].
  - Other encodings: word unchanged.
- rd==0: instruction still retires and counts; wEnable stays 0.
- retireCount wraps modulo 2^CNT_W.
- Reset asserted during WAIT_LOAD: pending load dropped, no write; a later response sets rspErr.

Optional Feature:
- Macro SMOL_WB_BYPASS_EN.
- Defined: adds outputs fwdValid (1), fwdAddr (5), fwdData (XLEN). They combinationally mirror wEnable/wAddr/wData, so decode can bypass a same-cycle RF read of the register being written. fwdValid=0 under reset.
- Undefined: these ports do not exist and there is no other behavioural difference.

Decomposition:
- Package smol_wb_pkg holds:
  - typedef enum for load funct3 codes (LB, LH, LW, LBU, LHU).
  - typedef enum for the state (IDLE, WAIT_LOAD).
  - XLEN constant.
- Sub-module smol_load_align: purely combinational; inputs word, funct3, offset; output formatted XLEN data. Instantiated once.

Test Plan:
- Reset, then an ALU op with rd=5, result 0x0000_0010, inRegWrite=1 -> one cycle later wEnable=1, wAddr=5, wData=0x10; retireCount=1.
- Load LB, address ending 2'b11, response 0x80FF_FF7F -> inReady=0 until response; then wData=0xFFFF_FF80 to the captured rd.
- Load LHU at offset 2'b10, response 0xBEEF_1234 -> wData=0x0000_BEEF.
- ALU op with rd=0, result 0xDEAD_BEEF -> wEnable stays 0; retireCount increments.
- Load accepted, then flush asserted with memRspValid in the same cycle -> no write, state IDLE, retireCount unchanged.
- memRspValid pulse while IDLE -> rspErr=1 and stays 1. Back-to-back ALU ops with inValid held high -> one write per cycle.
